// File: rtl/nes_lcd_pkg.sv
// nes_lcd_pkg: MTL panel raster timing, 2C02 palette and the scan pipeline sideband type
package nes_lcd_pkg;
  localparam int H_TOTAL = 1056;
  localparam int V_TOTAL = 525;
  localparam int H_SYNC  = 30;
  localparam int V_SYNC  = 13;
  localparam int H_ACT0  = 50;
  localparam int V_ACT0  = 23;
  localparam int H_ACT   = 800;
  localparam int V_ACT   = 480;
  localparam int WIN_X0  = 144;
  localparam int WIN_W   = 512;
  localparam logic [23:0] BORDER = 24'h000000;
  typedef struct packed {
    logic hsd;
    logic vsd;
    logic act;
    logic inwin;
    logic vbl;
  } lcd_ctl_t;
  localparam lcd_ctl_t CTL_RST = '{hsd: 1'b1, vsd: 1'b1, act: 1'b0, inwin: 1'b0, vbl: 1'b1};
  localparam logic [23:0] NES_PALETTE [64] = '{
    24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
    24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
    24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
    24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
    24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
    24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
    24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
    24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
  };
endpackage

// File: rtl/nes_palette_rom.sv
// nes_palette_rom: 6-bit NES palette index to registered 24-bit RGB
module nes_palette_rom
  import nes_lcd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  idx,
  output logic [23:0] rgb
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rgb <= '0;
    else     rgb <= NES_PALETTE[idx];
  end
endmodule

// File: rtl/mtl_lcd_scan.sv
// mtl_lcd_scan: MTL panel raster generator showing the 256x240 NES frame buffer at 2x2, centred
module mtl_lcd_scan
  import nes_lcd_pkg::*;
(
  input  logic        i_lcd_clk,
  input  logic        i_rst,
  input  logic        i_en,
  output logic [15:0] o_fb_addr,
  output logic        o_fb_rd,
  input  logic [5:0]  i_fb_data,
  output logic        o_dclk,
  output logic        o_hsd,
  output logic        o_vsd,
  output logic [7:0]  o_r,
  output logic [7:0]  o_g,
  output logic [7:0]  o_b,
  output logic        o_vblank
);
  logic [10:0] xcnt;
  logic [9:0]  ycnt;
  logic [7:0]  nx, ny;
  logic        yact;
  lcd_ctl_t    c0, c1, c2, c3;
  logic        en3;
  logic [23:0] pal;
  always_comb begin
    yact     = ycnt >= 10'(V_ACT0) && ycnt < 10'(V_ACT0 + V_ACT);
    c0.hsd   = xcnt >= 11'(H_SYNC);
    c0.vsd   = ycnt >= 10'(V_SYNC);
    c0.vbl   = !yact;
    c0.act   = yact && xcnt >= 11'(H_ACT0) && xcnt < 11'(H_ACT0 + H_ACT);
    c0.inwin = c0.act && xcnt >= 11'(H_ACT0 + WIN_X0) && xcnt < 11'(H_ACT0 + WIN_X0 + WIN_W);
    nx       = 8'((xcnt - 11'(H_ACT0 + WIN_X0)) >> 1);
    ny       = c0.act ? 8'((ycnt - 10'(V_ACT0)) >> 1) : '0;
  end
  always_ff @(posedge i_lcd_clk or posedge i_rst) begin
    if (i_rst) begin
      xcnt <= '0;
      ycnt <= '0;
    end else begin
      xcnt <= (xcnt == 11'(H_TOTAL - 1)) ? '0 : xcnt + 11'd1;
      if (xcnt == 11'(H_TOTAL - 1)) ycnt <= (ycnt == 10'(V_TOTAL - 1)) ? '0 : ycnt + 10'd1;
    end
  end
  // Sideband rides with the fetch so every pin describes the same raster position
  always_ff @(posedge i_lcd_clk or posedge i_rst) begin
    if (i_rst) begin
      c1        <= CTL_RST;
      c2        <= CTL_RST;
      c3        <= CTL_RST;
      en3       <= 1'b0;
      o_fb_rd   <= 1'b0;
      o_fb_addr <= '0;
    end else begin
      c1      <= c0;
      c2      <= c1;
      c3      <= c2;
      en3     <= i_en;
      o_fb_rd <= c0.inwin;
      if (c0.inwin) o_fb_addr <= {ny, nx};
    end
  end
  nes_palette_rom u_rom (.clk(i_lcd_clk), .rst(i_rst), .idx(i_fb_data), .rgb(pal));
  assign {o_r, o_g, o_b} = (!en3 || !c3.act) ? 24'h0 : !c3.inwin ? BORDER : pal;
  assign o_hsd    = c3.hsd;
  assign o_vsd    = c3.vsd;
  assign o_vblank = c3.vbl;
  assign o_dclk   = ~i_lcd_clk;
endmodule

// File: tb/tb_mtl_lcd_scan.sv
// tb_mtl_lcd_scan: directed checks of sync timing, window fetch, colour, enable and mid-line reset
module tb_mtl_lcd_scan;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic [5:0]  fb_data = '0;
  logic [15:0] fb_addr;
  logic        fb_rd, dclk, hsd, vsd, vblank;
  logic [7:0]  r, g, b;
  logic [23:0] rgb;
  int pass_cnt = 0;
  int total    = 0;
  int edges    = 0;

  mtl_lcd_scan dut (
    .i_lcd_clk(clk), .i_rst(rst), .i_en(en), .o_fb_addr(fb_addr), .o_fb_rd(fb_rd),
    .i_fb_data(fb_data), .o_dclk(dclk), .o_hsd(hsd), .o_vsd(vsd),
    .o_r(r), .o_g(g), .o_b(b), .o_vblank(vblank)
  );

  assign rgb = {r, g, b};
  always #5 clk = ~clk;
  always @(posedge clk) fb_data <= fb_addr[5:0];

  function automatic int pos(input int y, input int x);
    return y * 1056 + x;
  endfunction

  // Advance to the falling edge after rising edge number e since reset release
  task automatic step_to(input int e);
    if (edges < e) begin
      while (edges < e) begin
        @(posedge clk);
        edges++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    if (hsd !== 1'b1) $display("FAIL rst_hsd got %b exp 1", hsd); else pass_cnt++; total++;
    if (vsd !== 1'b1) $display("FAIL rst_vsd got %b exp 1", vsd); else pass_cnt++; total++;
    if (rgb !== 24'h0) $display("FAIL rst_rgb got %h exp 000000", rgb); else pass_cnt++; total++;
    if (fb_rd !== 1'b0) $display("FAIL rst_fb_rd got %b exp 0", fb_rd); else pass_cnt++; total++;
    if (fb_addr !== 16'h0) $display("FAIL rst_fb_addr got %h exp 0000", fb_addr); else pass_cnt++; total++;
    if (vblank !== 1'b1) $display("FAIL rst_vblank got %b exp 1", vblank); else pass_cnt++; total++;
    if (dclk !== ~clk) $display("FAIL dclk got %b exp %b", dclk, ~clk); else pass_cnt++; total++;
    rst = 1'b0;
    edges = 0;
    step_to(2);
    if (hsd !== 1'b1) $display("FAIL hsd_before_fall got %b exp 1", hsd); else pass_cnt++; total++;
    step_to(3);
    if (hsd !== 1'b0) $display("FAIL hsd_first_fall got %b exp 0", hsd); else pass_cnt++; total++;
  endtask

  task automatic test_sync;
    int nh = 0, nv = 0, nvb = 0;
    for (int p = 0; p < 14 * 1056; p++) begin
      step_to(p + 3);
      if (!hsd) nh++;
      if (!vsd) nv++;
      if (!vblank) nvb++;
    end
    if (nh !== 420) $display("FAIL hsd_low_cycles got %0d exp 420", nh); else pass_cnt++; total++;
    if (nv !== 13728) $display("FAIL vsd_low_cycles got %0d exp 13728", nv); else pass_cnt++; total++;
    if (nvb !== 0) $display("FAIL vblank_low_early got %0d exp 0", nvb); else pass_cnt++; total++;
  endtask

  task automatic test_window;
    int reads = 0;
    step_to(pos(23, 0) + 3);
    if (vblank !== 1'b0) $display("FAIL vblank_line23 got %b exp 0", vblank); else pass_cnt++; total++;
    step_to(pos(23, 193) + 1);
    if (fb_rd !== 1'b0) $display("FAIL rd_col143 got %b exp 0", fb_rd); else pass_cnt++; total++;
    step_to(pos(23, 194) + 1);
    if (fb_rd !== 1'b1) $display("FAIL rd_col144 got %b exp 1", fb_rd); else pass_cnt++; total++;
    if (fb_addr !== 16'h0000) $display("FAIL addr_col144 got %h exp 0000", fb_addr); else pass_cnt++; total++;
    step_to(pos(23, 193) + 3);
    if (rgb !== 24'h000000) $display("FAIL rgb_col143 got %h exp 000000", rgb); else pass_cnt++; total++;
    step_to(pos(23, 194) + 3);
    if (rgb !== 24'h7C7C7C) $display("FAIL rgb_col144 got %h exp 7c7c7c", rgb); else pass_cnt++; total++;
    step_to(pos(23, 196) + 3);
    if (rgb !== 24'h0000FC) $display("FAIL rgb_col146 got %h exp 0000fc", rgb); else pass_cnt++; total++;
    step_to(pos(23, 197) + 3);
    if (rgb !== 24'h0000FC) $display("FAIL rgb_col147 got %h exp 0000fc", rgb); else pass_cnt++; total++;
    step_to(pos(23, 198) + 3);
    if (rgb !== 24'h0000BC) $display("FAIL rgb_col148 got %h exp 0000bc", rgb); else pass_cnt++; total++;
    step_to(pos(23, 278) + 3);
    if (rgb !== 24'h58D854) $display("FAIL rgb_idx42 got %h exp 58d854", rgb); else pass_cnt++; total++;
    step_to(pos(23, 705) + 1);
    if (fb_rd !== 1'b1) $display("FAIL rd_col655 got %b exp 1", fb_rd); else pass_cnt++; total++;
    if (fb_addr !== 16'h00FF) $display("FAIL addr_col655 got %h exp 00ff", fb_addr); else pass_cnt++; total++;
    step_to(pos(23, 706) + 1);
    if (fb_rd !== 1'b0) $display("FAIL rd_col656 got %b exp 0", fb_rd); else pass_cnt++; total++;
    if (fb_addr !== 16'h00FF) $display("FAIL addr_hold got %h exp 00ff", fb_addr); else pass_cnt++; total++;
    step_to(pos(23, 706) + 3);
    if (rgb !== 24'h000000) $display("FAIL rgb_col656 got %h exp 000000", rgb); else pass_cnt++; total++;
    step_to(pos(23, 850) + 1);
    if (fb_rd !== 1'b0) $display("FAIL rd_x850 got %b exp 0", fb_rd); else pass_cnt++; total++;
    step_to(pos(23, 850) + 3);
    if (rgb !== 24'h000000) $display("FAIL rgb_x850 got %h exp 000000", rgb); else pass_cnt++; total++;
    for (int x = 0; x < 1056; x++) begin
      step_to(pos(24, x) + 1);
      if (fb_rd) reads++;
      if (x == 196 && rgb !== 24'h7C7C7C) begin
        $display("FAIL rgb_line24_col144 got %h exp 7c7c7c", rgb);
      end else if (x == 196) pass_cnt++;
      if (x == 198 && rgb !== 24'h0000FC) begin
        $display("FAIL rgb_line24_col146 got %h exp 0000fc", rgb);
      end else if (x == 198) pass_cnt++;
      if (x == 196 || x == 198) total++;
    end
    if (reads !== 512) $display("FAIL reads_per_line got %0d exp 512", reads); else pass_cnt++; total++;
    step_to(pos(25, 705) + 1);
    if (fb_addr !== 16'h01FF) $display("FAIL addr_line25 got %h exp 01ff", fb_addr); else pass_cnt++; total++;
  endtask

  task automatic test_enable;
    step_to(pos(26, 29) + 3);
    if (hsd !== 1'b0) $display("FAIL en_hsd_x29 got %b exp 0", hsd); else pass_cnt++; total++;
    step_to(pos(26, 30) + 3);
    if (hsd !== 1'b1) $display("FAIL en_hsd_x30 got %b exp 1", hsd); else pass_cnt++; total++;
    step_to(pos(26, 193) + 3);
    en = 1'b0;
    step_to(pos(26, 194) + 3);
    if (rgb !== 24'h000000) $display("FAIL en_off_col144 got %h exp 000000", rgb); else pass_cnt++; total++;
    step_to(pos(26, 230) + 3);
    if (rgb !== 24'h000000) $display("FAIL en_off_col180 got %h exp 000000", rgb); else pass_cnt++; total++;
    step_to(pos(27, 29) + 3);
    if (hsd !== 1'b0) $display("FAIL en_off_hsd_x29 got %b exp 0", hsd); else pass_cnt++; total++;
    step_to(pos(27, 30) + 3);
    if (hsd !== 1'b1) $display("FAIL en_off_hsd_x30 got %b exp 1", hsd); else pass_cnt++; total++;
    step_to(pos(27, 193) + 3);
    en = 1'b1;
    step_to(pos(27, 194) + 3);
    if (rgb !== 24'h7C7C7C) $display("FAIL en_on_col144 got %h exp 7c7c7c", rgb); else pass_cnt++; total++;
    step_to(pos(27, 230) + 3);
    if (rgb !== 24'h0058F8) $display("FAIL en_on_col180 got %h exp 0058f8", rgb); else pass_cnt++; total++;
  endtask

  task automatic test_reset_midline;
    step_to(pos(28, 400) + 3);
    if (rgb !== 24'hFCA044) $display("FAIL pre_rst_rgb got %h exp fca044", rgb); else pass_cnt++; total++;
    if (fb_addr !== 16'h0268) $display("FAIL pre_rst_addr got %h exp 0268", fb_addr); else pass_cnt++; total++;
    rst = 1'b1;
    #1;
    if (hsd !== 1'b1) $display("FAIL mid_rst_hsd got %b exp 1", hsd); else pass_cnt++; total++;
    if (rgb !== 24'h0) $display("FAIL mid_rst_rgb got %h exp 000000", rgb); else pass_cnt++; total++;
    if (fb_rd !== 1'b0) $display("FAIL mid_rst_fb_rd got %b exp 0", fb_rd); else pass_cnt++; total++;
    if (fb_addr !== 16'h0) $display("FAIL mid_rst_fb_addr got %h exp 0000", fb_addr); else pass_cnt++; total++;
    if (vblank !== 1'b1) $display("FAIL mid_rst_vblank got %b exp 1", vblank); else pass_cnt++; total++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    edges = 0;
    step_to(2);
    if (hsd !== 1'b1) $display("FAIL restart_hsd_e2 got %b exp 1", hsd); else pass_cnt++; total++;
    step_to(3);
    if (hsd !== 1'b0) $display("FAIL restart_hsd_e3 got %b exp 0", hsd); else pass_cnt++; total++;
    step_to(pos(22, 1055) + 3);
    if (vblank !== 1'b1) $display("FAIL restart_vblank_l22 got %b exp 1", vblank); else pass_cnt++; total++;
    step_to(pos(23, 0) + 3);
    if (vblank !== 1'b0) $display("FAIL restart_vblank_l23 got %b exp 0", vblank); else pass_cnt++; total++;
    step_to(pos(23, 194) + 3);
    if (rgb !== 24'h7C7C7C) $display("FAIL restart_rgb_col144 got %h exp 7c7c7c", rgb); else pass_cnt++; total++;
  endtask

  initial begin
    test_reset;
    test_sync;
    test_window;
    test_enable;
    test_reset_midline;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
